// File: rtl/pid_chn_scheduler.sv
// pid_chn_scheduler
//   Time-shares one PID core between NUM_CHN motor channels. Each channel
//   latches its latest RPM sample and a pending bit. A round-robin arbiter
//   picks one pending channel at a time and presents one data beat
//   (channel, feedback, reference) to the PID core. The scheduler then waits
//   for that channel's result or for a timeout before issuing the next beat.
//
// Ports
//   clk, rstn        clock, asynchronous active-low reset
//   rpm_valid_i/_data_i  per-channel sample strobe and packed samples
//   tr_valid_i/_chn_i/_data_i  setpoint (reference) write
//   stop_i           per-channel stop, forces the issued reference to 0
//   tready_i         PID core accepts the current beat
//   data_*_o         beat to the PID core (valid/chn/fdb/ref)
//   u_valid_i/_chn_i PID result strobe and its channel
//   busy_o           FSM not idle
//   overrun_o        sticky, a sample was overwritten before it was issued
//   timeout_o        one-cycle pulse when a result wait expires
module pid_chn_scheduler #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_CHN     = 4,
    parameter int CHN_WIDTH   = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_CHN-1:0]            rpm_valid_i,
    input  logic [NUM_CHN*DATA_WIDTH-1:0] rpm_data_i,
    input  logic                          tr_valid_i,
    input  logic [CHN_WIDTH-1:0]          tr_chn_i,
    input  logic [DATA_WIDTH-1:0]         tr_data_i,
    input  logic [NUM_CHN-1:0]            stop_i,
    input  logic                          tready_i,
    output logic                          data_valid_o,
    output logic [CHN_WIDTH-1:0]          data_chn_o,
    output logic [DATA_WIDTH-1:0]         data_fdb_o,
    output logic [DATA_WIDTH-1:0]         data_ref_o,
    input  logic                          u_valid_i,
    input  logic [CHN_WIDTH-1:0]          u_chn_i,
    output logic                          busy_o,
    output logic [NUM_CHN-1:0]            overrun_o,
    output logic                          timeout_o
);
    localparam int IDX_W = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_U} state_e;

    state_e                               state_q;
    logic [IDX_W-1:0]                     grant_q, last_q;
    logic [IDX_W-1:0]                     rr_idx, rr_c;
    logic                                 rr_hit;
    logic [NUM_CHN-1:0]                   pend_q, pend_d, ovr_d;
    logic [NUM_CHN-1:0][DATA_WIDTH-1:0]   smp_q, smp_d, ref_q, ref_d;
    logic [CNT_W-1:0]                     cnt_q;
    logic                                 hshk, u_match;

    assign hshk    = (state_q == ISSUE) && data_valid_o && tready_i;
    // data_chn_o holds the granted channel for the whole beat lifetime
    assign u_match = (state_q == WAIT_U) && u_valid_i && (u_chn_i == data_chn_o);

    // Round-robin: scan downward so the candidate nearest last_grant+1 wins
    always_comb begin
        rr_hit = 1'b0;
        rr_idx = '0;
        rr_c   = '0;
        for (int i = NUM_CHN; i >= 1; i--) begin
            rr_c = IDX_W'((int'(last_q) + i) % NUM_CHN);
            if (pend_q[rr_c]) begin
                rr_hit = 1'b1;
                rr_idx = rr_c;
            end
        end
    end

    // Per-channel sample/pending/reference store
    always_comb begin
        pend_d = pend_q;
        ovr_d  = overrun_o;
        smp_d  = smp_q;
        ref_d  = ref_q;
        if (hshk) pend_d[grant_q] = 1'b0;
        for (int k = 0; k < NUM_CHN; k++) begin
            if (rpm_valid_i[k]) begin
                smp_d[k]  = rpm_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                pend_d[k] = 1'b1;
                // a sample landing on the handshake edge is fresh, not an overrun
                if (pend_q[k] && !(hshk && grant_q == IDX_W'(k))) ovr_d[k] = 1'b1;
            end
        end
        if (tr_valid_i && (int'(tr_chn_i) < NUM_CHN)) ref_d[tr_chn_i[IDX_W-1:0]] = tr_data_i;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_q    <= '0;
            smp_q     <= '0;
            ref_q     <= '0;
            overrun_o <= '0;
        end else begin
            pend_q    <= pend_d;
            smp_q     <= smp_d;
            ref_q     <= ref_d;
            overrun_o <= ovr_d;
        end
    end

    // FSM with registered outputs. The beat payload is captured on ISSUE
    // entry, so later ref/stop changes cannot disturb a beat in flight.
    // WAIT_U lasts at most TIMEOUT_CYC cycles; timeout_o shows in the next one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_q       <= IDX_W'(NUM_CHN - 1);
            cnt_q        <= '0;
            data_valid_o <= 1'b0;
            data_chn_o   <= '0;
            data_fdb_o   <= '0;
            data_ref_o   <= '0;
            busy_o       <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rr_hit) begin
                        state_q      <= ISSUE;
                        busy_o       <= 1'b1;
                        grant_q      <= rr_idx;
                        data_valid_o <= 1'b1;
                        data_chn_o   <= CHN_WIDTH'(rr_idx);
                        data_fdb_o   <= smp_q[rr_idx];
                        data_ref_o   <= stop_i[rr_idx] ? '0 : ref_q[rr_idx];
                    end
                end
                ISSUE: begin
                    if (tready_i) begin
                        state_q      <= WAIT_U;
                        data_valid_o <= 1'b0;
                        last_q       <= grant_q;
                        cnt_q        <= '0;
                    end
                end
                WAIT_U: begin
                    if (u_match) begin
                        state_q <= IDLE;
                        busy_o  <= 1'b0;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state_q   <= IDLE;
                        busy_o    <= 1'b0;
                        timeout_o <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pid_chn_scheduler.sv
// Testbench for pid_chn_scheduler: directed scenarios plus randomized rounds.
// Expected beats are pushed to a queue when stimulus is issued; a monitor
// pops and compares on every handshake, and also watches payload hold,
// single-outstanding-beat and busy behaviour.
module tb_pid_chn_scheduler;
    localparam int DW = 16;
    localparam int NC = 4;
    localparam int CW = 3;
    localparam int TO = 16;

    logic               clk, rstn;
    logic [NC-1:0]      rpm_valid_i;
    logic [NC*DW-1:0]   rpm_data_i;
    logic               tr_valid_i;
    logic [CW-1:0]      tr_chn_i;
    logic [DW-1:0]      tr_data_i;
    logic [NC-1:0]      stop_i;
    logic               tready_i;
    logic               data_valid_o;
    logic [CW-1:0]      data_chn_o;
    logic [DW-1:0]      data_fdb_o, data_ref_o;
    logic               u_valid_i;
    logic [CW-1:0]      u_chn_i;
    logic               busy_o;
    logic [NC-1:0]      overrun_o;
    logic               timeout_o;

    pid_chn_scheduler #(.DATA_WIDTH(DW), .NUM_CHN(NC), .CHN_WIDTH(CW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rstn(rstn),
        .rpm_valid_i(rpm_valid_i), .rpm_data_i(rpm_data_i),
        .tr_valid_i(tr_valid_i), .tr_chn_i(tr_chn_i), .tr_data_i(tr_data_i),
        .stop_i(stop_i), .tready_i(tready_i),
        .data_valid_o(data_valid_o), .data_chn_o(data_chn_o),
        .data_fdb_o(data_fdb_o), .data_ref_o(data_ref_o),
        .u_valid_i(u_valid_i), .u_chn_i(u_chn_i),
        .busy_o(busy_o), .overrun_o(overrun_o), .timeout_o(timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] chn;
        logic [DW-1:0] fdb;
        logic [DW-1:0] rf;
    } beat_t;

    beat_t        exp_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           hs_count = 0;
    int           m_last = NC - 1;
    logic [DW-1:0] model_ref[NC];

    // ---------------- monitor / scoreboard ----------------
    logic          in_flight = 1'b0;
    logic [CW-1:0] hs_chn = '0;
    logic          prev_stall = 1'b0, prev_vld = 1'b0;
    beat_t         prev_pl = '0;

    always @(negedge clk) begin
        beat_t e, a;
        a = '{chn: data_chn_o, fdb: data_fdb_o, rf: data_ref_o};
        if (!rstn) begin
            in_flight  = 1'b0;
            prev_stall = 1'b0;
            prev_vld   = 1'b0;
        end else begin
            if (prev_stall) begin
                n_tests++;
                if (!data_valid_o || a != prev_pl) begin
                    n_fail++;
                    $display("FAIL hold: valid=%0b beat=%h required valid=1 beat=%h", data_valid_o, a, prev_pl);
                end
            end
            if (data_valid_o && !prev_vld) begin
                n_tests++;
                if (in_flight) begin
                    n_fail++;
                    $display("FAIL one_outstanding: new beat chn=%0d while chn=%0d in flight", data_chn_o, hs_chn);
                end
            end
            if (data_valid_o && tready_i) begin
                n_tests++;
                hs_count++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: chn=%0d fdb=%0d ref=%0d, none expected", a.chn, a.fdb, a.rf);
                end else begin
                    e = exp_q.pop_front();
                    if (a != e) begin
                        n_fail++;
                        $display("FAIL beat: got chn=%0d fdb=%0d ref=%0d required chn=%0d fdb=%0d ref=%0d",
                                 a.chn, a.fdb, a.rf, e.chn, e.fdb, e.rf);
                    end
                end
                in_flight = 1'b1;
                hs_chn    = data_chn_o;
            end else if (in_flight) begin
                if ((u_valid_i && u_chn_i == hs_chn) || timeout_o) begin
                    in_flight = 1'b0;
                end else begin
                    n_tests++;
                    if (!busy_o) begin
                        n_fail++;
                        $display("FAIL busy_wait: busy=0 while waiting on chn=%0d, required 1", hs_chn);
                    end
                end
            end
            prev_stall = data_valid_o && !tready_i;
            prev_pl    = a;
            prev_vld   = data_valid_o;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Expected beats: pending channels leave in circular order after the last grant
    task automatic push_round(input logic [NC-1:0] mask, input logic [NC-1:0][DW-1:0] d);
        beat_t b;
        int    base, c;
        base = m_last;
        for (int i = 1; i <= NC; i++) begin
            c = (base + i) % NC;
            if (mask[c]) begin
                b.chn = CW'(c);
                b.fdb = d[c];
                b.rf  = stop_i[c] ? '0 : model_ref[c];
                exp_q.push_back(b);
                m_last = c;
            end
        end
    endtask

    task automatic pulse_rpm(input logic [NC-1:0] mask, input logic [NC-1:0][DW-1:0] d);
        tick();
        rpm_valid_i = mask;
        rpm_data_i  = d;
        tick();
        rpm_valid_i = '0;
    endtask

    task automatic write_ref(input logic [CW-1:0] ch, input logic [DW-1:0] v);
        tick();
        tr_valid_i = 1'b1; tr_chn_i = ch; tr_data_i = v;
        tick();
        tr_valid_i = 1'b0;
        if (ch < CW'(NC)) model_ref[ch[1:0]] = v;
    endtask

    task automatic respond(input logic [CW-1:0] ch);
        tick();
        u_valid_i = 1'b1; u_chn_i = ch;
        tick();
        u_valid_i = 1'b0;
    endtask

    task automatic model_reset();
        m_last = NC - 1;
        exp_q.delete();
        for (int k = 0; k < NC; k++) model_ref[k] = '0;
    endtask

    task automatic check_outputs_zero(input string nm);
        chk({nm, "_ctrl"}, {57'd0, data_valid_o, busy_o, timeout_o, overrun_o}, 64'd0);
        chk({nm, "_payload"}, {29'd0, data_chn_o, data_fdb_o, data_ref_o}, 64'd0);
    endtask

    task automatic wait_hs(input string nm);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(data_valid_o && tready_i) && k < 60);
        if (!(data_valid_o && tready_i)) chk({nm, "_hs_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        do begin
            @(negedge clk); #1;
            k++;
        end while ((busy_o || data_valid_o) && k < 100);
        if (busy_o || data_valid_o) chk({nm, "_idle_timeout"}, 64'd0, 64'd1);
    endtask

    // Random backpressure and result delays (with stray wrong-channel results)
    task automatic drain(input string nm);
        logic          rsp_on;
        logic [CW-1:0] rsp_chn;
        int            rsp_dly, k;
        logic [2:0]    w;
        rsp_on = 1'b0; rsp_chn = '0; rsp_dly = 0; k = 0;
        forever begin
            tick();
            u_valid_i = 1'b0;
            if (rsp_on) begin
                if (rsp_dly == 0) begin
                    u_valid_i = 1'b1; u_chn_i = rsp_chn; rsp_on = 1'b0;
                end else begin
                    rsp_dly--;
                    if ($urandom_range(0, 3) == 0) begin
                        w = 3'($urandom_range(1, 7));
                        u_valid_i = 1'b1; u_chn_i = rsp_chn ^ w;
                    end
                end
            end
            tready_i = ($urandom_range(0, 2) != 0);
            @(negedge clk); #1;
            k++;
            if (data_valid_o && tready_i) begin
                rsp_on = 1'b1; rsp_chn = data_chn_o; rsp_dly = $urandom_range(0, 4);
            end
            if (exp_q.size() == 0 && !rsp_on && !busy_o && !data_valid_o && !u_valid_i) break;
            if (k > 400) begin
                chk({nm, "_drain_timeout"}, 64'd0, 64'd1);
                break;
            end
        end
        tick();
        u_valid_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [NC-1:0][DW-1:0] d;
        logic [NC-1:0]         mask;
        logic [CW-1:0]         ch;
        logic [DW-1:0]         v;
        int                    hs0, nw, nvld;

        rstn = 1'b0; rpm_valid_i = '0; rpm_data_i = '0; tr_valid_i = 1'b0; tr_chn_i = '0;
        tr_data_i = '0; stop_i = '0; tready_i = 1'b0; u_valid_i = 1'b0; u_chn_i = '0;
        model_reset();
        tick(); #2;
        check_outputs_zero("reset");
        tick();
        rstn = 1'b1;

        // Round robin from reset: 0,1,2,3 then 0 first again
        for (int k = 0; k < NC; k++) write_ref(CW'(k), DW'(1000 + k));
        d = {16'd13, 16'd12, 16'd11, 16'd10};
        push_round(4'b1111, d);
        pulse_rpm(4'b1111, d);
        drain("rr1");
        d = {16'd23, 16'd22, 16'd21, 16'd20};
        push_round(4'b0101, d);
        pulse_rpm(4'b0101, d);
        drain("rr2");

        // Single request and two-cycle latency
        tready_i = 1'b1;
        write_ref(3'd1, 16'd200);
        d = '0; d[1] = 16'd150;
        push_round(4'b0010, d);
        pulse_rpm(4'b0010, d);
        @(negedge clk); chk("lat_early", {63'd0, data_valid_o}, 64'd0);
        @(negedge clk); chk("lat_ontime", {63'd0, data_valid_o}, 64'd1);
        @(negedge clk); chk("single_busy_wait", {63'd0, busy_o}, 64'd1);
        respond(3'd1);
        @(negedge clk); chk("single_busy_done", {63'd0, busy_o}, 64'd0);

        // Backpressure with ref/stop changes while the beat is held
        tready_i = 1'b0;
        hs0 = hs_count;
        write_ref(3'd3, 16'd333);
        d = '0; d[3] = 16'd444;
        push_round(4'b1000, d);
        pulse_rpm(4'b1000, d);
        @(negedge clk);
        @(negedge clk);
        chk("bp_issue", {63'd0, data_valid_o}, 64'd1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i == 1) begin
                tr_valid_i = 1'b1; tr_chn_i = 3'd3; tr_data_i = 16'd999; stop_i = 4'b1000;
                model_ref[3] = 16'd999;
            end
            if (i == 2) tr_valid_i = 1'b0;
            @(negedge clk);
            chk("bp_payload", {data_valid_o, 12'd0, data_chn_o, data_fdb_o, data_ref_o},
                {1'b1, 12'd0, 3'd3, 16'd444, 16'd333});
        end
        tick(); tready_i = 1'b1;
        repeat (4) tick();
        chk("bp_one_handshake", 64'(hs_count - hs0), 64'd1);
        stop_i = '0;
        respond(3'd3);
        wait_idle("bp");

        // Overrun while blocked in WAIT_U on channel 0, stop on channel 2
        d = '0; d[0] = 16'd55;
        push_round(4'b0001, d);
        pulse_rpm(4'b0001, d);
        wait_hs("ovr_ch0");
        write_ref(3'd2, 16'd777);
        stop_i = 4'b0100;
        d = '0; d[2] = 16'd100;
        pulse_rpm(4'b0100, d);
        @(negedge clk); chk("ovr_first", {60'd0, overrun_o}, 64'd0);
        d[2] = 16'd120;
        pulse_rpm(4'b0100, d);
        @(negedge clk); chk("ovr_second", {60'd0, overrun_o}, 64'h4);
        push_round(4'b0100, d);
        respond(3'd0);
        wait_hs("ovr_ch2");
        respond(3'd2);
        wait_idle("ovr");
        stop_i = '0;

        // Timeout with a stray wrong-channel result
        tready_i = 1'b1;
        d = '0; d[1] = 16'd321;
        push_round(4'b0010, d);
        pulse_rpm(4'b0010, d);
        wait_hs("to");
        for (int n = 1; n <= TO + 2; n++) begin
            tick();
            u_valid_i = (n == 3);
            u_chn_i   = 3'd2;
            @(negedge clk);
            if (n <= TO) chk("to_wait", {62'd0, timeout_o, busy_o}, 64'h1);
            else if (n == TO + 1) chk("to_pulse", {62'd0, timeout_o, busy_o}, 64'h2);
            else chk("to_done", {62'd0, timeout_o, busy_o}, 64'h0);
        end

        // Randomized rounds
        for (int r = 0; r < 40; r++) begin
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++) begin
                ch = CW'($urandom_range(0, 7));
                v  = DW'($urandom);
                write_ref(ch, v);
            end
            stop_i = NC'($urandom);
            mask   = NC'($urandom_range(1, 15));
            for (int k = 0; k < NC; k++) d[k] = DW'($urandom);
            push_round(mask, d);
            pulse_rpm(mask, d);
            drain("rand");
            stop_i = '0;
        end

        // Reset in WAIT_U with another channel pending
        tready_i = 1'b1;
        d = '0; d[3] = 16'd42;
        push_round(4'b1000, d);
        pulse_rpm(4'b1000, d);
        wait_hs("rst_ch3");
        d[1] = 16'd43;
        pulse_rpm(4'b0010, d);
        tick();
        rstn = 1'b0;
        #2;
        check_outputs_zero("rst_mid");
        tick();
        rstn = 1'b1;
        model_reset();
        nvld = 0;
        repeat (20) begin
            @(negedge clk);
            if (data_valid_o || busy_o) nvld++;
        end
        chk("rst_no_beat", 64'(nvld), 64'd0);
        d = '0; d[0] = 16'd7;
        push_round(4'b0001, d);
        pulse_rpm(4'b0001, d);
        drain("post_rst");

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pid_chn_scheduler.md
PID_CHN_SCHEDULER -- requirements
Module: pid_chn_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, 16, width of feedback, reference and RPM words.
REQ-002 Parameter NUM_CHN, 4, number of motor channels sharing one PID core.
REQ-003 Parameter CHN_WIDTH, 3, width of channel index fields.
REQ-004 Parameter TIMEOUT_CYC, 1024, maximum cycles to wait for the PID result.
REQ-005 Port clk, input, 1, single clock; all logic on rising edge.
REQ-006 Port rstn, input, 1, asynchronous active-low reset.
REQ-007 Port rpm_valid_i, input, NUM_CHN, one-cycle strobe per channel; new RPM sample present.
REQ-008 Port rpm_data_i, input, NUM_CHN*DATA_WIDTH, packed RPM samples; channel k in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port tr_valid_i / tr_chn_i / tr_data_i, input, 1 / CHN_WIDTH / DATA_WIDTH, setpoint write strobe, target channel, new reference.
REQ-010 Port stop_i, input, NUM_CHN, per-channel stop; forces that channel's issued reference to 0.
REQ-011 Port tready_i, input, 1, PID core ready to accept a data beat.
REQ-012 Port data_valid_o / data_chn_o / data_fdb_o / data_ref_o, output, 1 / CHN_WIDTH / DATA_WIDTH / DATA_WIDTH, data beat to the PID core.
REQ-013 Port u_valid_i / u_chn_i, input, 1 / CHN_WIDTH, PID result strobe and its channel.
REQ-014 Port busy_o, output, 1, high whenever the FSM is not IDLE.
REQ-015 Port overrun_o, output, NUM_CHN, sticky flag; sample overwritten before it was issued.
REQ-016 Port timeout_o, output, 1, one-cycle pulse when a result wait expires.

Function
REQ-017 A per-channel sample register and pending bit SHALL be loaded on rpm_valid_i[k]: sample <= rpm_data_i slice, pending[k] <= 1.
REQ-018 If rpm_valid_i[k] arrives while pending[k]=1, the sample SHALL be overwritten and overrun_o[k] set; it stays set until reset.
REQ-019 A tr_valid_i with tr_chn_i < NUM_CHN SHALL update ref[tr_chn_i] next edge; tr_chn_i >= NUM_CHN SHALL be ignored.
REQ-020 The FSM SHALL have states IDLE, ISSUE and WAIT_U.
REQ-021 IDLE: if any pending bit is set, grant round-robin starting at (last_grant+1) mod NUM_CHN, then go to ISSUE; otherwise stay.
REQ-022 On entry to ISSUE, the outputs SHALL load data_chn_o=grant, data_fdb_o=sample[grant], and data_ref_o = stop_i[grant] ? 0 : ref[grant].
REQ-023 data_valid_o SHALL be high in ISSUE, with its payload held stable until the cycle where data_valid_o & tready_i (the handshake).
REQ-024 On handshake: pending[grant] cleared, last_grant <= grant, go to WAIT_U, data_valid_o low next cycle.
REQ-025 If rpm_valid_i[grant] coincides with the handshake, the new sample SHALL be kept and pending stays 1; no overrun is flagged.
REQ-026 WAIT_U: u_valid_i with u_chn_i == grant SHALL return the FSM to IDLE; u_valid_i on any other channel SHALL be ignored.
REQ-027 WAIT_U SHALL count cycles; at TIMEOUT_CYC without a match, pulse timeout_o and return to IDLE.
REQ-028 Latency: with an idle FSM and tready_i=1, data_valid_o SHALL assert in the second cycle after the edge sampling rpm_valid_i.
REQ-029 Only one beat SHALL be outstanding at the PID core at a time.
REQ-030 Changes to ref or stop after the ISSUE entry SHALL NOT alter the beat in flight.

Reset
REQ-031 On rstn low, asynchronously:
- FSM to IDLE
- pending, samples, refs, overrun_o, counter to 0
- last_grant = NUM_CHN-1
- data_valid_o, busy_o, timeout_o = 0
- data_chn_o, data_fdb_o, data_ref_o = 0
REQ-032 Reset mid-ISSUE or mid-WAIT_U SHALL drop the beat with no further data_valid_o.

Verification
REQ-033 Single request: ref[1]=200, rpm_valid_i=0010 with sample 150, tready_i=1 -> data_valid_o high 2 cycles later with chn=1, fdb=150, ref=200; u_valid_i chn=1 -> busy_o=0.
REQ-034 Round robin: all four pending at once, results returned promptly -> beats issued in channel order 0,1,2,3, then 0 next round.
REQ-035 Backpressure: tready_i low for 5 cycles in ISSUE -> data_valid_o and payload held for 5 cycles; exactly one handshake.
REQ-036 Overrun/stop: channel 2 sampled twice (100 then 120) before grant, with stop_i[2]=1 -> overrun_o[2]=1, beat shows fdb=120, ref=0.
REQ-037 Timeout: no u_valid_i after handshake (TIMEOUT_CYC=16) -> timeout_o pulses at cycle 16, FSM returns to IDLE; a wrong-channel u_valid_i earlier is ignored.
REQ-038 Reset mid-WAIT_U: rstn pulsed low -> all outputs 0 immediately, pending cleared, no beat issued afterward.
